// File: rtl/priority_encoder_pkg.sv
// Shared constants and helpers for the registered round-robin priority encoder.
package priority_encoder_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Number of bits needed to hold an index in the range 0..w-1.
  function automatic int clog2_w(input int w);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < w) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_rr_select.sv
// Combinational selector: the highest set request at or below base wins, wrapping at 0.
module pe_rr_select
  import priority_encoder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OUT_W = clog2_w(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [OUT_W-1:0] ptr,
  input  logic             mode,
  output logic [OUT_W-1:0] sel,
  output logic             any
);

  logic [OUT_W-1:0] base;
  logic [WIDTH-1:0] rot;
  logic [OUT_W-1:0] top_idx;

  // Fixed priority is round-robin with the search always starting at the top index.
  assign base = (mode == MODE_FIXED) ? OUT_W'(WIDTH - 1) : ptr;

  // Rotate so that req[base] lands on the MSB, then take the highest set bit.
  always_comb begin
    rot     = '0;
    top_idx = '0;
    for (int j = 0; j < WIDTH; j++) begin
      rot[j] = req[OUT_W'(j + 1 + int'(base))];
    end
    for (int j = 0; j < WIDTH; j++) begin
      if (rot[j]) top_idx = OUT_W'(j);
    end
  end

  assign sel = top_idx + base + OUT_W'(1);
  assign any = |req;

endmodule

// File: rtl/priority_encoder_rr.sv
// Sticky request capture feeding a registered valid/ready index output, fixed or round-robin.
module priority_encoder_rr
  import priority_encoder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OUT_W = clog2_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enable,
  input  logic             mode,
  output logic [OUT_W-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] pending
);

  // Handshake: a grant transfers on any rising edge where out_valid & out_ready;
  // while out_valid & !out_ready, data_out and out_valid stay frozen.
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] cap, clr_mask;
  logic [OUT_W-1:0] data_out_q;
  logic [OUT_W-1:0] ptr_q, ptr_d;
  logic [OUT_W-1:0] sel;
  logic             valid_q, accept, load, any;

  assign accept = valid_q & out_ready;
  assign load   = ~valid_q | accept;
  assign cap    = enable ? data_in : '0;

  always_comb begin
    clr_mask = '0;
    if (accept) clr_mask[data_out_q] = 1'b1;
  end

  // Set beats clear, so a fresh request on the bit being granted stays pending.
  assign pending_d = (pending_q & ~clr_mask) | cap;
  assign ptr_d     = (accept && mode == MODE_RR) ? data_out_q - OUT_W'(1) : ptr_q;

  // Selecting on next-state values drops the accepted bit and advances the pointer at once.
  pe_rr_select #(
    .WIDTH (WIDTH),
    .OUT_W (OUT_W)
  ) u_select (
    .req  (pending_d),
    .ptr  (ptr_d),
    .mode (mode),
    .sel  (sel),
    .any  (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      ptr_q      <= OUT_W'(WIDTH - 1);
    end else begin
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      if (load) begin
        valid_q <= any;
        if (any) data_out_q <= sel;
      end
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = valid_q;
  assign pending   = pending_q;

endmodule
